fifo_uart_tx: RTL and testbench
===============================

// Module: fifo_uart_tx
// PURPOSE
//  Serial transmitter that drains the FIFO from its read side. It pops one
//  word whenever the FIFO is non-empty and the transmitter is idle. Each word
//  goes out as an 8N1-style frame on tx: start bit, WIDTH data bits LSB first,
//  stop bit. It sits directly downstream of FIFO: drives its read_request and
//  consumes its empty and data_out.
// PARAMETERS
//  WIDTH         8   data bits per frame; must equal the FIFO WIDTH
//  CLKS_PER_BIT  16  clk cycles per serial bit; must be >= 2
// PORTS
//  clk           in   1      single clock; all state changes on rising edge
//  reset         in   1      asynchronous, active-high reset
//  empty         in   1      FIFO empty flag
//  read_request  out  1      pop request to FIFO; one-cycle pulse
//  data_in       in   WIDTH  FIFO data_out; valid the cycle after read_request
//  tx            out  1      serial line; idles high
//  busy          out  1      high while a word is latched or being sent
//  frame_done    out  1      one-cycle pulse in last cycle of stop bit
// BEHAVIOUR
//  Reset, asynchronous and active-high:
//   - state=IDLE, tx=1, busy=0, frame_done=0, counters=0, shift reg=0
//   - read_request is forced 0 while reset is high
//   - asserting reset mid-frame aborts the frame at once: tx=1, word dropped
//  FSM states: IDLE, LATCH, START, DATA, STOP
//  - IDLE: read_request = !empty (combinational, gated by reset)
//     - if !empty: go to LATCH; else stay in IDLE
//  - LATCH: FIFO data is valid this cycle; shift reg <= data_in
//     - go to START; read_request=0
//  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA
//  - DATA: tx=shift[0] for each bit
//     - each bit lasts CLKS_PER_BIT cycles; then shift right, bit_cnt++
//     - after WIDTH bits go to STOP
//  - STOP: tx=1 for CLKS_PER_BIT cycles
//     - frame_done=1 in the final cycle
//     - then go to IDLE
//  Outputs by state:
//   - busy=1 in LATCH, START, DATA, STOP; 0 in IDLE
//   - tx is registered-equivalent; glitch-free, changes only on clk edges
//  Counters:
//   - baud_cnt is $clog2(CLKS_PER_BIT) bits; runs 0..CLKS_PER_BIT-1 and
//     wraps to 0 at each bit boundary
//   - bit_cnt is $clog2(WIDTH)+1 bits
//  Timing:
//   - read_request to first tx=0 cycle is 2 cycles (IDLE->LATCH->START)
//   - frame is (WIDTH+2)*CLKS_PER_BIT cycles, START through STOP
//   - back-to-back words: 1 IDLE + 1 LATCH cycle of tx=1 beyond the stop bit
//  Boundaries:
//   - at most one read_request per frame; never issued outside IDLE
//   - never issued while empty=1, so an empty FIFO is never underflowed
//   - empty changing during START/DATA/STOP is ignored until IDLE
//   - FIFO reset with this block is safe: read_request is 0 during reset
// TESTING (WIDTH=8, CLKS_PER_BIT=4)
//  1. empty=1 for 200 cycles after reset
//     -> read_request never high; tx=1; busy=0
//  2. one word 0xA5
//     -> exactly 1 read_request pulse
//     -> 2 cycles later tx carries 0,1,0,1,0,0,1,0,1,1, each for 4 cycles
//     -> frame_done pulses once, in cycle 40 of the frame
//  3. two words 0x00,0xFF queued
//     -> 2 read_request pulses 42 cycles apart
//     -> tx=1 for 6 cycles between frames (4 stop + IDLE + LATCH)
//  4. reset asserted mid-DATA, async with no clk edge
//     -> tx=1, busy=0 immediately; next word after release is sent intact
//  5. empty falls during the DATA bits of frame 1
//     -> no read_request until the cycle after frame_done
//  6. CLKS_PER_BIT=2, word 0x01
//     -> bit widths all 2 cycles; LSB bit is 1, the rest 0

Source files
------------

// File: rtl/fifo_uart_tx.sv
// Serial transmitter that pops words from an upstream FIFO and sends each one
// as a start bit, WIDTH data bits LSB first, and a stop bit.
module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             empty,
  output logic             read_request,
  input  logic [WIDTH-1:0] data_in,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, LATCH, START, DATA, STOP} state_t;

  state_t           state, state_n;
  logic [BW-1:0]    baud_cnt, baud_n;
  logic [CW-1:0]    bit_cnt, bit_n;
  logic [WIDTH-1:0] shift_q, shift_n;
  logic             tx_q, tx_n;
  logic             pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      shift_q  <= shift_n;
      tx_q     <= tx_n;
    end
  end

  always_comb begin
    state_n    = state;
    baud_n     = baud_cnt;
    bit_n      = bit_cnt;
    shift_n    = shift_q;
    pop        = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        baud_n = '0;
        bit_n  = '0;
        if (!empty) begin
          pop     = 1'b1;
          state_n = LATCH;
        end
      end
      LATCH: begin
        shift_n = data_in;
        state_n = START;
      end
      START: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_n  = '0;
          state_n = DATA;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_n  = '0;
          shift_n = shift_q >> 1;
          if (bit_cnt == BIT_LAST) begin
            bit_n   = '0;
            state_n = STOP;
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud_cnt == BAUD_LAST) begin
          frame_done = 1'b1;
          baud_n     = '0;
          state_n    = IDLE;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // tx is the registered line level for the state being entered, so the
    // serial output only ever changes on a clock edge.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  assign read_request = pop & ~reset;
  assign busy         = (state != IDLE);
  assign tx           = tx_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: one instance at 4 clocks/bit, one at 2.
module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       empty1, empty2;
  logic [7:0] data1, data2;
  logic       rr1, rr2, tx1, tx2, busy1, busy2, fd1, fd2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) dut1 (
    .clk(clk), .reset(reset), .empty(empty1), .read_request(rr1),
    .data_in(data1), .tx(tx1), .busy(busy1), .frame_done(fd1)
  );

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(2)) dut2 (
    .clk(clk), .reset(reset), .empty(empty2), .read_request(rr2),
    .data_in(data2), .tx(tx2), .busy(busy2), .frame_done(fd2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Stretch a 10-bit frame (bit 0 = start bit) to cpb samples per bit.
  function automatic logic [39:0] expand(input logic [9:0] f, input int cpb);
    logic [39:0] r = '0;
    for (int k = 0; k < 10 * cpb; k++) r[k] = f[k / cpb];
    return r;
  endfunction

  task automatic wait_rr(input bit sel, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if ((sel ? rr2 : rr1) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic capture(input bit sel, input int cpb, input int chg_at,
                         input logic chg_empty, input logic [7:0] chg_data,
                         output logic [39:0] txv, output logic [39:0] fdv,
                         output int rrc);
    txv = '0;
    fdv = '0;
    rrc = 0;
    for (int i = 0; i < 10 * cpb; i++) begin
      @(negedge clk);
      txv[i] = sel ? tx2 : tx1;
      fdv[i] = sel ? fd2 : fd1;
      if ((sel ? rr2 : rr1) === 1'b1) rrc++;
      if (i == chg_at) begin
        if (sel) begin
          empty2 = chg_empty;
          data2  = chg_data;
        end else begin
          empty1 = chg_empty;
          data1  = chg_data;
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] txv, fdv;
    int          rrc;
    bit          ok, seen_rr, seen_low, seen_busy;

    reset  = 1'b1;
    empty1 = 1'b0;
    empty2 = 1'b1;
    data1  = 8'h00;
    data2  = 8'h00;

    // Reset state; read_request held low even though empty is low.
    @(negedge clk);
    check("rst_tx", tx1, 1);
    check("rst_busy", busy1, 0);
    check("rst_fd", fd1, 0);
    check("rst_rr_gated", rr1, 0);
    empty1 = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // 1: empty FIFO for 200 cycles
    seen_rr = 0; seen_low = 0; seen_busy = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rr1 !== 1'b0) seen_rr = 1;
      if (tx1 !== 1'b1) seen_low = 1;
      if (busy1 !== 1'b0) seen_busy = 1;
    end
    check("t1_no_rr", seen_rr, 0);
    check("t1_tx_high", seen_low, 0);
    check("t1_not_busy", seen_busy, 0);

    // 2: single word 0xA5
    data1 = 8'hA5; empty1 = 1'b0;
    wait_rr(0, ok);
    check("t2_rr", ok, 1);
    @(negedge clk);
    check("t2_latch_tx", tx1, 1);
    check("t2_latch_busy", busy1, 1);
    check("t2_latch_rr", rr1, 0);
    empty1 = 1'b1;
    capture(0, 4, 1000, 1'b1, 8'h00, txv, fdv, rrc);
    check("t2_tx", txv, expand(10'b1101001010, 4));
    check("t2_fd", fdv, 40'h80_0000_0000);
    check("t2_rr_cnt", rrc, 0);
    @(negedge clk);
    check("t2_idle_busy", busy1, 0);
    check("t2_idle_rr", rr1, 0);

    // 3: back-to-back 0x00 then 0xFF
    data1 = 8'h00; empty1 = 1'b0;
    wait_rr(0, ok);
    check("t3_rr1", ok, 1);
    @(negedge clk);
    check("t3_latch1_tx", tx1, 1);
    capture(0, 4, 0, 1'b0, 8'hFF, txv, fdv, rrc);
    check("t3_tx1", txv, expand(10'b1000000000, 4));
    check("t3_rr_cnt1", rrc, 0);
    @(negedge clk);
    check("t3_rr2_gap42", rr1, 1);
    check("t3_idle_tx", tx1, 1);
    @(negedge clk);
    check("t3_latch2_tx", tx1, 1);
    empty1 = 1'b1;
    capture(0, 4, 1000, 1'b1, 8'h00, txv, fdv, rrc);
    check("t3_tx2", txv, expand(10'b1111111110, 4));
    check("t3_fd2", fdv, 40'h80_0000_0000);

    // 4: asynchronous reset in the middle of DATA
    @(negedge clk);
    data1 = 8'h81; empty1 = 1'b0;
    wait_rr(0, ok);
    check("t4_rr", ok, 1);
    @(negedge clk);
    empty1 = 1'b1;
    for (int i = 0; i < 12; i++) @(negedge clk);
    check("t4_pre_tx", tx1, 0);
    check("t4_pre_busy", busy1, 1);
    #2 reset = 1'b1;
    #1;
    check("t4_rst_tx", tx1, 1);
    check("t4_rst_busy", busy1, 0);
    data1 = 8'h96; empty1 = 1'b0;
    #1;
    check("t4_rst_rr", rr1, 0);
    @(negedge clk);
    reset = 1'b0;
    wait_rr(0, ok);
    check("t4_rr_after", ok, 1);
    @(negedge clk);
    empty1 = 1'b1;
    capture(0, 4, 1000, 1'b1, 8'h00, txv, fdv, rrc);
    check("t4_tx", txv, expand(10'b1100101100, 4));

    // 5: empty falls during DATA of the first frame
    @(negedge clk);
    data1 = 8'h3C; empty1 = 1'b0;
    wait_rr(0, ok);
    check("t5_rr1", ok, 1);
    @(negedge clk);
    empty1 = 1'b1;
    capture(0, 4, 15, 1'b0, 8'h5A, txv, fdv, rrc);
    check("t5_tx1", txv, expand(10'b1001111000, 4));
    check("t5_rr_in_frame", rrc, 0);
    @(negedge clk);
    check("t5_rr_after_fd", rr1, 1);
    @(negedge clk);
    empty1 = 1'b1;
    capture(0, 4, 1000, 1'b1, 8'h00, txv, fdv, rrc);
    check("t5_tx2", txv, expand(10'b1010110100, 4));

    // 6: two clocks per bit, word 0x01
    data2 = 8'h01; empty2 = 1'b0;
    wait_rr(1, ok);
    check("t6_rr", ok, 1);
    @(negedge clk);
    check("t6_latch_busy", busy2, 1);
    empty2 = 1'b1;
    capture(1, 2, 1000, 1'b1, 8'h00, txv, fdv, rrc);
    check("t6_tx", txv, expand(10'b1000000010, 2));
    check("t6_fd", fdv, 40'h00_0008_0000);
    check("t6_rr_cnt", rrc, 0);
    @(negedge clk);
    check("t6_idle_busy", busy2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
